mem_access_ctrl: RTL and testbench
==================================

Name: mem_access_ctrl

Overview:
Memory-stage consumer of the EX/MEM pipeline register outputs. It turns the M-stage load/store controls, address and store data into one SRAM-like data-bus transaction. It aligns and extends load data, and raises a memory stall until the bus response returns. It also detects address-alignment exceptions and discards in-flight responses when the M stage is flushed.

Parameters:
ADDR_W, 32, data-bus address width
DATA_W, 32, data-bus data width (only 32 supported)

Ports:
clk  in  1  clock
rst  in  1  reset, synchronous, active-high
flushM  in  1  M-stage flush (exception/eret)
stallM  in  1  global M-stage stall from hazard unit (already ORs in mem_stallM)
mem_readM  in  1  load in M
mem_writeM  in  1  store in M
mem_sizeM  in  2  0 byte, 1 half, 2 word
mem_signedM  in  1  sign-extend load
except_pendM  in  1  older exception already flagged (overflow/ri/syscall/break/eret)
aluoutM  in  32  effective address
rt_valueM  in  32  store source
data_req  out  1  bus request
data_wr  out  1  1 write, 0 read
data_size  out  2  bus size, same encoding as mem_sizeM
data_addr  out  32  bus address
data_wdata  out  32  lane-replicated store data
data_wstrb  out  4  byte enables (0 for reads)
data_addr_ok  in  1  request accepted
data_data_ok  in  1  response valid; always at least 1 cycle after addr_ok
data_rdata  in  32  read data
rdataM  out  32  aligned/extended load result
mem_stallM  out  1  stall request to hazard unit
adelM  out  1  load address error
adesM  out  1  store address error
badvaddrM  out  32  faulting address (= aluoutM when adelM/adesM)

Behaviour:
- Misalignment: half with addr[0]!=0, or word with addr[1:0]!=0, is misaligned. adelM/adesM = access & misaligned (combinational); badvaddrM = aluoutM.
- go = (mem_readM|mem_writeM) & ~misaligned & ~except_pendM & ~flushM.
- States: IDLE, REQ, WAIT, DRAIN, DONE. Reset -> IDLE.
- All outputs at reset: data_req 0, data_wstrb 0, mem_stallM 0, rdataM 0, killed flag 0, captured addr/wdata/strb/size/wr regs 0.
- IDLE:
  - data_req = go; bus fields driven combinationally from M inputs and captured into regs.
  - go & addr_ok -> WAIT; go & ~addr_ok -> REQ; otherwise stay.
  - mem_stallM = go.
- REQ:
  - data_req = 1; bus fields from captured regs, stable until accepted.
  - flushM sets killed.
  - addr_ok -> DRAIN if (killed|flushM), else WAIT.
  - mem_stallM = 1.
- WAIT:
  - data_req = 0.
  - flushM & ~data_ok -> DRAIN.
  - flushM & data_ok -> IDLE, data discarded.
  - data_ok -> DONE, rdataM latched.
  - mem_stallM = 1.
- DRAIN:
  - waits for data_ok of the killed access, then -> IDLE; data discarded, rdataM unchanged.
  - mem_stallM = 1, stalling the new M occupant.
  - killed cleared on exit.
- DONE:
  - mem_stallM = 0; rdataM held.
  - ~stallM or flushM -> IDLE, so the next M instruction is sampled next cycle.
  - Stays in DONE while other stall sources hold stallM; no re-issue.
- Minimum latency: addr_ok in issue cycle, data_ok next cycle -> DONE; stall drops 2 cycles after issue.
- Store data:
  - byte: {4{rt[7:0]}}, wstrb = 1<<addr[1:0].
  - half: {2{rt[15:0]}}, wstrb = addr[1] ? 4'b1100 : 4'b0011.
  - word: rt, wstrb = 4'b1111.
- Load extraction:
  - shift data_rdata right by addr[1:0]*8 (captured address).
  - byte takes [7:0], half [15:0], word all bits.
  - sign-extend if mem_signedM (captured), else zero-extend.
- Writes also wait for data_ok before DONE.
- Simultaneous flushM with go in IDLE: no request issued.
- Reset mid-transaction returns to IDLE immediately; the bus side is reset by the same rst.

Decomposition:
- Shared package cpu_mem_pkg:
  - size encodings SZ_BYTE/SZ_HALF/SZ_WORD
  - FSM state enum
  - strobe constants
- One natural sub-module: mem_align (combinational store lane-replication/strobe and load extract/extend), reused by the cache refill path.

Test Plan:
- LW addr 0x1000, addr_ok same cycle, data_ok next with 0xDEADBEEF -> data_req 1 cycle, stall 2 cycles, rdataM 0xDEADBEEF.
- LB addr 0x1003, rdata 0x80xxxxxx, signed -> rdataM 0xFFFFFF80; LBU -> 0x00000080.
- SH addr 0x2002, rt 0x1234ABCD -> wdata 0xABCDABCD, wstrb 4'b1100, wr 1, no rdataM change.
- LW addr 0x1001 -> adelM 1, badvaddrM 0x1001, data_req never asserted, mem_stallM 0.
- LW accepted, flushM in WAIT, data_ok 3 cycles later -> DRAIN, stall held until data_ok, rdataM unchanged, returns to IDLE.
- addr_ok delayed 4 cycles, flushM pulse during REQ -> data_req held with stable addr, then DRAIN; after data_ok, external stallM held high 2 cycles in the DONE case of a separate load -> no re-issue.

Source files
------------

// File: rtl/cpu_mem_pkg.sv
// Shared definitions for the memory-stage data-bus path: access sizes,
// controller states, byte-strobe constants and alignment helpers.
package cpu_mem_pkg;

  localparam logic [1:0] SZ_BYTE = 2'd0;
  localparam logic [1:0] SZ_HALF = 2'd1;
  localparam logic [1:0] SZ_WORD = 2'd2;

  localparam logic [3:0] STRB_NONE    = 4'b0000;
  localparam logic [3:0] STRB_ALL     = 4'b1111;
  localparam logic [3:0] STRB_HALF_LO = 4'b0011;
  localparam logic [3:0] STRB_HALF_HI = 4'b1100;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_REQ   = 3'd1,
    ST_WAIT  = 3'd2,
    ST_DRAIN = 3'd3,
    ST_DONE  = 3'd4
  } mem_state_e;

  function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] addr_lo);
    logic mis;
    case (size)
      SZ_HALF: mis = addr_lo[0];
      SZ_WORD: mis = (addr_lo != 2'b00);
      default: mis = 1'b0;
    endcase
    return mis;
  endfunction

  function automatic logic [3:0] byte_strb(input logic [1:0] addr_lo);
    logic [3:0] s;
    case (addr_lo)
      2'd0:    s = 4'b0001;
      2'd1:    s = 4'b0010;
      2'd2:    s = 4'b0100;
      default: s = 4'b1000;
    endcase
    return s;
  endfunction

endpackage

// File: rtl/mem_access_ctrl_if.sv
// SRAM-like data bus between the M-stage access controller (master) and memory (slave).
interface mem_access_ctrl_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic              data_req;
  logic              data_wr;
  logic [1:0]        data_size;
  logic [ADDR_W-1:0] data_addr;
  logic [DATA_W-1:0] data_wdata;
  logic [3:0]        data_wstrb;
  logic              data_addr_ok;
  logic              data_data_ok;
  logic [DATA_W-1:0] data_rdata;

  modport master (
    output data_req, data_wr, data_size, data_addr, data_wdata, data_wstrb,
    input  data_addr_ok, data_data_ok, data_rdata
  );

  modport slave (
    input  data_req, data_wr, data_size, data_addr, data_wdata, data_wstrb,
    output data_addr_ok, data_data_ok, data_rdata
  );
endinterface

// File: rtl/mem_align.sv
// Combinational lane handling: store-data replication with byte strobes, and
// load-data extraction with sign/zero extension. Shared with the cache refill path.
module mem_align
  import cpu_mem_pkg::*;
(
  input  logic [1:0]  st_size_i,
  input  logic [1:0]  st_addr_lo_i,
  input  logic [31:0] st_data_i,
  output logic [31:0] st_wdata_o,
  output logic [3:0]  st_strb_o,
  input  logic [1:0]  ld_size_i,
  input  logic [1:0]  ld_addr_lo_i,
  input  logic        ld_signed_i,
  input  logic [31:0] ld_rdata_i,
  output logic [31:0] ld_data_o
);

  logic [31:0] lane_s;

  // Store side: replicate the source across every lane it may land in.
  always_comb begin
    st_wdata_o = st_data_i;
    st_strb_o  = STRB_ALL;
    case (st_size_i)
      SZ_BYTE: begin
        st_wdata_o = {4{st_data_i[7:0]}};
        st_strb_o  = byte_strb(st_addr_lo_i);
      end
      SZ_HALF: begin
        st_wdata_o = {2{st_data_i[15:0]}};
        st_strb_o  = st_addr_lo_i[1] ? STRB_HALF_HI : STRB_HALF_LO;
      end
      default: begin
        st_wdata_o = st_data_i;
        st_strb_o  = STRB_ALL;
      end
    endcase
  end

  // Load side: bring the addressed lane down to bit 0, then extend.
  always_comb begin
    case (ld_addr_lo_i)
      2'd0:    lane_s = ld_rdata_i;
      2'd1:    lane_s = {8'h00, ld_rdata_i[31:8]};
      2'd2:    lane_s = {16'h0000, ld_rdata_i[31:16]};
      default: lane_s = {24'h000000, ld_rdata_i[31:24]};
    endcase
    case (ld_size_i)
      SZ_BYTE: ld_data_o = {{24{ld_signed_i & lane_s[7]}}, lane_s[7:0]};
      SZ_HALF: ld_data_o = {{16{ld_signed_i & lane_s[15]}}, lane_s[15:0]};
      default: ld_data_o = lane_s;
    endcase
  end

endmodule

// File: rtl/mem_access_ctrl.sv
// M-stage data-bus access controller: issues one bus transaction per load/store,
// stalls until the response, aligns load data and discards responses of flushed accesses.
module mem_access_ctrl
  import cpu_mem_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flushM,
  input  logic              stallM,
  input  logic              mem_readM,
  input  logic              mem_writeM,
  input  logic [1:0]        mem_sizeM,
  input  logic              mem_signedM,
  input  logic              except_pendM,
  input  logic [ADDR_W-1:0] aluoutM,
  input  logic [DATA_W-1:0] rt_valueM,
  output logic [DATA_W-1:0] rdataM,
  output logic              mem_stallM,
  output logic              adelM,
  output logic              adesM,
  output logic [ADDR_W-1:0] badvaddrM,
  mem_access_ctrl_if.master bus
);

  mem_state_e        state_q;
  logic              killed_q;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] wdata_q;
  logic [3:0]        strb_q;
  logic [1:0]        size_q;
  logic              wr_q;
  logic              signed_q;
  logic [DATA_W-1:0] rdata_q;

  logic              misaligned_s;
  logic              go_s;
  logic [DATA_W-1:0] st_wdata_s;
  logic [3:0]        st_strb_s;
  logic [DATA_W-1:0] ld_data_s;

  logic              req_s;
  logic              stall_s;
  logic              wr_s;
  logic [1:0]        size_s;
  logic [ADDR_W-1:0] addr_s;
  logic [DATA_W-1:0] wdata_s;
  logic [3:0]        strb_s;

  assign misaligned_s = is_misaligned(mem_sizeM, aluoutM[1:0]);
  assign adelM        = mem_readM & misaligned_s;
  assign adesM        = mem_writeM & misaligned_s;
  assign badvaddrM    = aluoutM;
  assign go_s         = (mem_readM | mem_writeM) & ~misaligned_s & ~except_pendM & ~flushM;

  mem_align u_align (
    .st_size_i    (mem_sizeM),
    .st_addr_lo_i (aluoutM[1:0]),
    .st_data_i    (rt_valueM),
    .st_wdata_o   (st_wdata_s),
    .st_strb_o    (st_strb_s),
    .ld_size_i    (size_q),
    .ld_addr_lo_i (addr_q[1:0]),
    .ld_signed_i  (signed_q),
    .ld_rdata_i   (bus.data_rdata),
    .ld_data_o    (ld_data_s)
  );

  // Bus fields come straight from M in the issue cycle, then from the captured copy.
  always_comb begin
    req_s   = 1'b0;
    stall_s = 1'b0;
    wr_s    = wr_q;
    size_s  = size_q;
    addr_s  = addr_q;
    wdata_s = wdata_q;
    strb_s  = strb_q;
    case (state_q)
      ST_IDLE: begin
        req_s   = go_s;
        stall_s = go_s;
        wr_s    = mem_writeM;
        size_s  = mem_sizeM;
        addr_s  = aluoutM;
        wdata_s = st_wdata_s;
        strb_s  = (go_s & mem_writeM) ? st_strb_s : STRB_NONE;
      end
      ST_REQ: begin
        req_s   = 1'b1;
        stall_s = 1'b1;
      end
      ST_WAIT, ST_DRAIN: stall_s = 1'b1;
      ST_DONE:           stall_s = 1'b0;
      default: begin
        req_s   = 1'b0;
        stall_s = 1'b0;
      end
    endcase
  end

  assign bus.data_req   = req_s & ~rst;
  assign bus.data_wr    = wr_s;
  assign bus.data_size  = size_s;
  assign bus.data_addr  = addr_s;
  assign bus.data_wdata = wdata_s;
  assign bus.data_wstrb = rst ? STRB_NONE : strb_s;
  assign mem_stallM     = stall_s & ~rst;
  assign rdataM         = rdata_q;

  // Access sequencing; a killed access still owns the bus until its response drains.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      killed_q <= 1'b0;
      addr_q   <= {ADDR_W{1'b0}};
      wdata_q  <= {DATA_W{1'b0}};
      strb_q   <= STRB_NONE;
      size_q   <= 2'b00;
      wr_q     <= 1'b0;
      signed_q <= 1'b0;
      rdata_q  <= {DATA_W{1'b0}};
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (go_s) begin
            addr_q   <= aluoutM;
            wdata_q  <= st_wdata_s;
            strb_q   <= mem_writeM ? st_strb_s : STRB_NONE;
            size_q   <= mem_sizeM;
            wr_q     <= mem_writeM;
            signed_q <= mem_signedM;
            state_q  <= bus.data_addr_ok ? ST_WAIT : ST_REQ;
          end
        end
        ST_REQ: begin
          killed_q <= killed_q | flushM;
          if (bus.data_addr_ok) begin
            state_q <= (killed_q | flushM) ? ST_DRAIN : ST_WAIT;
          end
        end
        ST_WAIT: begin
          if (bus.data_data_ok) begin
            if (!flushM && !wr_q) begin
              rdata_q <= ld_data_s;
            end
            state_q <= flushM ? ST_IDLE : ST_DONE;
          end else if (flushM) begin
            killed_q <= 1'b1;
            state_q  <= ST_DRAIN;
          end
        end
        ST_DRAIN: begin
          if (bus.data_data_ok) begin
            killed_q <= 1'b0;
            state_q  <= ST_IDLE;
          end
        end
        ST_DONE: begin
          if (!stallM || flushM) begin
            state_q <= ST_IDLE;
          end
        end
        default: begin
          killed_q <= 1'b0;
          state_q  <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Directed-vector bench for mem_access_ctrl with a transaction-level model of
// bus requests, exceptions and load results, plus literal spot values.
module tb_mem_access_ctrl;

  logic        clk = 1'b0;
  logic        rst, flushM, ext_stall, stallM;
  logic        mem_readM, mem_writeM, mem_signedM, except_pendM;
  logic [1:0]  mem_sizeM;
  logic [31:0] aluoutM, rt_valueM, rdataM, badvaddrM;
  logic        mem_stallM, adelM, adesM;

  always #5 clk = ~clk;

  mem_access_ctrl_if #(.ADDR_W(32), .DATA_W(32)) bus ();

  // Hazard unit: global M stall is the controller's own stall OR other sources.
  assign stallM = mem_stallM | ext_stall;

  mem_access_ctrl #(.ADDR_W(32), .DATA_W(32)) dut (
    .clk          (clk),
    .rst          (rst),
    .flushM       (flushM),
    .stallM       (stallM),
    .mem_readM    (mem_readM),
    .mem_writeM   (mem_writeM),
    .mem_sizeM    (mem_sizeM),
    .mem_signedM  (mem_signedM),
    .except_pendM (except_pendM),
    .aluoutM      (aluoutM),
    .rt_valueM    (rt_valueM),
    .rdataM       (rdataM),
    .mem_stallM   (mem_stallM),
    .adelM        (adelM),
    .adesM        (adesM),
    .badvaddrM    (badvaddrM),
    .bus          (bus)
  );

  typedef struct {
    logic        rst, exc, rd, wr, sgn, flush, ext, aok, dok, ereq, estall;
    logic [1:0]  sz;
    logic [31:0] addr, rt, rdata;
    int          ln;
    int          lk [3];
    logic [31:0] lv [3];
  } vec_t;

  vec_t vq[$];
  int checks = 0;
  int failures = 0;

  logic        cur_rst, cur_exc, cur_rd, cur_wr, cur_sgn;
  logic [1:0]  cur_sz;
  logic [31:0] cur_addr, cur_rt;

  // transaction model state
  logic        pend_v, pend_wr, pend_sgn, pend_kill;
  logic [1:0]  pend_sz;
  logic [31:0] pend_addr, pend_rt;
  logic        out_v, out_wr, out_sgn, out_kill;
  logic [1:0]  out_sz;
  logic [31:0] out_addr;
  logic [31:0] exp_rdata;

  function automatic logic mis_m(input logic [1:0] sz, input logic [31:0] a);
    return (sz == 2'd1 && a[0]) || (sz == 2'd2 && a[1:0] != 2'b00);
  endfunction

  function automatic logic [31:0] wdata_m(input logic [1:0] sz, input logic [31:0] rt);
    if (sz == 2'd0) return {rt[7:0], rt[7:0], rt[7:0], rt[7:0]};
    else if (sz == 2'd1) return {rt[15:0], rt[15:0]};
    else return rt;
  endfunction

  function automatic logic [3:0] strb_m(input logic [1:0] sz, input logic [31:0] a);
    if (sz == 2'd0) return 4'b0001 << a[1:0];
    else if (sz == 2'd1) return a[1] ? 4'b1100 : 4'b0011;
    else return 4'b1111;
  endfunction

  function automatic logic [31:0] load_m(input logic [1:0] sz, input logic sgn,
                                         input logic [31:0] a, input logic [31:0] rd);
    logic [31:0] s;
    s = rd >> (32'(a[1:0]) * 8);
    if (sz == 2'd0) return sgn ? 32'($signed(s[7:0])) : {24'h0, s[7:0]};
    else if (sz == 2'd1) return sgn ? 32'($signed(s[15:0])) : {16'h0, s[15:0]};
    else return s;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic instr(input logic rd, input logic wr, input logic [1:0] sz, input logic sgn,
                       input logic [31:0] addr, input logic [31:0] rt);
    cur_rd = rd; cur_wr = wr; cur_sz = sz; cur_sgn = sgn; cur_addr = addr; cur_rt = rt;
  endtask

  task automatic nop();
    instr(1'b0, 1'b0, 2'd2, 1'b0, 32'h0, 32'h0);
  endtask

  task automatic cyc(input logic flush, input logic ext, input logic aok, input logic dok,
                     input logic [31:0] rdata, input logic ereq, input logic estall);
    vec_t v;
    v.rst = cur_rst; v.exc = cur_exc; v.rd = cur_rd; v.wr = cur_wr; v.sgn = cur_sgn;
    v.sz = cur_sz; v.addr = cur_addr; v.rt = cur_rt;
    v.flush = flush; v.ext = ext; v.aok = aok; v.dok = dok; v.rdata = rdata;
    v.ereq = ereq; v.estall = estall; v.ln = 0;
    for (int k = 0; k < 3; k++) begin v.lk[k] = 0; v.lv[k] = 32'h0; end
    vq.push_back(v);
  endtask

  task automatic idle();
    cyc(1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0);
  endtask

  // kinds: 1 rdataM, 2 data_wdata, 3 data_wstrb, 4 data_addr, 5 badvaddrM, 6 {adesM,adelM}
  task automatic lit(input int kind, input logic [31:0] val);
    vec_t v;
    v = vq.pop_back();
    v.lk[v.ln] = kind; v.lv[v.ln] = val; v.ln++;
    vq.push_back(v);
  endtask

  initial begin
    rst = 1'b1; flushM = 1'b0; ext_stall = 1'b0; mem_readM = 1'b0; mem_writeM = 1'b0;
    mem_sizeM = 2'd2; mem_signedM = 1'b0; except_pendM = 1'b0; aluoutM = 32'h0; rt_valueM = 32'h0;
    bus.data_addr_ok = 1'b0; bus.data_data_ok = 1'b0; bus.data_rdata = 32'h0;
    pend_v = 1'b0; out_v = 1'b0; exp_rdata = 32'h0;
    pend_wr = 1'b0; pend_sgn = 1'b0; pend_kill = 1'b0; pend_sz = 2'd0; pend_addr = 32'h0; pend_rt = 32'h0;
    out_wr = 1'b0; out_sgn = 1'b0; out_kill = 1'b0; out_sz = 2'd0; out_addr = 32'h0;

    // reset
    cur_rst = 1'b1; cur_exc = 1'b0; nop();
    idle(); lit(1, 32'h0); idle();
    cur_rst = 1'b0; idle();
    // LW 0x1000, addr_ok at issue, data_ok next cycle
    instr(1'b1, 1'b0, 2'd2, 1'b0, 32'h1000, 32'h0);
    cyc(1'b0, 1'b0, 1'b1, 1'b0, 32'h0, 1'b1, 1'b1); lit(4, 32'h1000); lit(3, 32'h0);
    cyc(1'b0, 1'b0, 1'b0, 1'b1, 32'hDEADBEEF, 1'b0, 1'b1);
    idle();
    nop(); idle(); lit(1, 32'hDEADBEEF);
    // LB / LBU 0x1003
    instr(1'b1, 1'b0, 2'd0, 1'b1, 32'h1003, 32'h0);
    cyc(1'b0, 1'b0, 1'b1, 1'b0, 32'h0, 1'b1, 1'b1);
    cyc(1'b0, 1'b0, 1'b0, 1'b1, 32'h80123456, 1'b0, 1'b1);
    idle(); lit(1, 32'hFFFFFF80);
    instr(1'b1, 1'b0, 2'd0, 1'b0, 32'h1003, 32'h0);
    cyc(1'b0, 1'b0, 1'b1, 1'b0, 32'h0, 1'b1, 1'b1);
    cyc(1'b0, 1'b0, 1'b0, 1'b1, 32'h80123456, 1'b0, 1'b1);
    idle();
    nop(); idle(); lit(1, 32'h00000080);
    // SH 0x2002
    instr(1'b0, 1'b1, 2'd1, 1'b0, 32'h2002, 32'h1234ABCD);
    cyc(1'b0, 1'b0, 1'b1, 1'b0, 32'h0, 1'b1, 1'b1); lit(2, 32'hABCDABCD); lit(3, 32'hC);
    cyc(1'b0, 1'b0, 1'b0, 1'b1, 32'hFFFFFFFF, 1'b0, 1'b1);
    idle(); lit(1, 32'h00000080);
    // SB 0x3001 with addr_ok one cycle late
    instr(1'b0, 1'b1, 2'd0, 1'b0, 32'h3001, 32'h000000EF);
    cyc(1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 1'b1, 1'b1); lit(2, 32'hEFEFEFEF); lit(3, 32'h2);
    cyc(1'b0, 1'b0, 1'b1, 1'b0, 32'h0, 1'b1, 1'b1); lit(4, 32'h3001);
    cyc(1'b0, 1'b0, 1'b0, 1'b1, 32'h0, 1'b0, 1'b1);
    idle();
    // misaligned / suppressed accesses
    instr(1'b1, 1'b0, 2'd2, 1'b0, 32'h1001, 32'h0); idle(); lit(5, 32'h1001); lit(6, 32'h1);
    instr(1'b1, 1'b0, 2'd1, 1'b0, 32'h1001, 32'h0); idle(); lit(6, 32'h1);
    instr(1'b0, 1'b1, 2'd2, 1'b0, 32'h2002, 32'h0); idle(); lit(6, 32'h2);
    cur_exc = 1'b1;
    instr(1'b1, 1'b0, 2'd2, 1'b0, 32'h1000, 32'h0); idle();
    cur_exc = 1'b0;
    cyc(1'b1, 1'b0, 1'b1, 1'b0, 32'h0, 1'b0, 1'b0);
    nop(); idle();
    // LW accepted, flushed in WAIT, response 3 cycles later drained
    instr(1'b1, 1'b0, 2'd2, 1'b0, 32'h1004, 32'h0);
    cyc(1'b0, 1'b0, 1'b1, 1'b0, 32'h0, 1'b1, 1'b1);
    cyc(1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 1'b1);
    instr(1'b1, 1'b0, 2'd2, 1'b0, 32'h1008, 32'h0);
    cyc(1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 1'b1);
    cyc(1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 1'b1);
    cyc(1'b0, 1'b0, 1'b0, 1'b1, 32'h55555555, 1'b0, 1'b1);
    cyc(1'b0, 1'b0, 1'b1, 1'b0, 32'h0, 1'b1, 1'b1); lit(1, 32'h00000080); lit(4, 32'h1008);
    cyc(1'b0, 1'b0, 1'b0, 1'b1, 32'h0BADF00D, 1'b0, 1'b1);
    idle();
    nop(); idle(); lit(1, 32'h0BADF00D);
    // addr_ok 4 cycles late, flush during REQ, then DONE held by external stall
    instr(1'b1, 1'b0, 2'd2, 1'b0, 32'h1010, 32'h0);
    cyc(1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 1'b1, 1'b1);
    cyc(1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 1'b1, 1'b1);
    instr(1'b1, 1'b0, 2'd2, 1'b0, 32'h1020, 32'h0);
    cyc(1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 1'b1, 1'b1); lit(4, 32'h1010);
    cyc(1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 1'b1, 1'b1);
    cyc(1'b0, 1'b0, 1'b1, 1'b0, 32'h0, 1'b1, 1'b1); lit(4, 32'h1010);
    cyc(1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 1'b1);
    cyc(1'b0, 1'b0, 1'b0, 1'b1, 32'h77777777, 1'b0, 1'b1);
    cyc(1'b0, 1'b0, 1'b1, 1'b0, 32'h0, 1'b1, 1'b1); lit(4, 32'h1020);
    cyc(1'b0, 1'b0, 1'b0, 1'b1, 32'h13572468, 1'b0, 1'b1);
    cyc(1'b0, 1'b1, 1'b1, 1'b0, 32'h0, 1'b0, 1'b0);
    cyc(1'b0, 1'b1, 1'b1, 1'b0, 32'h0, 1'b0, 1'b0);
    idle();
    nop(); idle(); lit(1, 32'h13572468);
    // flush in the same cycle as data_ok
    instr(1'b1, 1'b0, 2'd2, 1'b0, 32'h1030, 32'h0);
    cyc(1'b0, 1'b0, 1'b1, 1'b0, 32'h0, 1'b1, 1'b1);
    cyc(1'b1, 1'b0, 1'b0, 1'b1, 32'h99999999, 1'b0, 1'b1);
    nop(); idle(); lit(1, 32'h13572468);
    // reset mid-request
    instr(1'b1, 1'b0, 2'd2, 1'b0, 32'h1040, 32'h0);
    cyc(1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 1'b1, 1'b1);
    cur_rst = 1'b1; idle();
    cur_rst = 1'b0; nop(); idle(); lit(1, 32'h0);
    idle();

    for (int i = 0; i < vq.size(); i++) begin
      vec_t v;
      logic mis;
      v = vq[i];
      @(negedge clk);
      rst = v.rst; except_pendM = v.exc; mem_readM = v.rd; mem_writeM = v.wr;
      mem_sizeM = v.sz; mem_signedM = v.sgn; aluoutM = v.addr; rt_valueM = v.rt;
      flushM = v.flush; ext_stall = v.ext;
      bus.data_addr_ok = v.aok; bus.data_data_ok = v.dok; bus.data_rdata = v.rdata;
      #2;
      if (v.ereq && !pend_v) begin
        pend_v = 1'b1; pend_wr = v.wr; pend_sz = v.sz; pend_sgn = v.sgn;
        pend_addr = v.addr; pend_rt = v.rt; pend_kill = 1'b0;
      end
      chk("data_req", 32'(bus.data_req), 32'(v.ereq));
      chk("mem_stallM", 32'(mem_stallM), 32'(v.estall));
      chk("rdataM", rdataM, exp_rdata);
      mis = mis_m(v.sz, v.addr);
      chk("adelM", 32'(adelM), 32'(v.rd & mis));
      chk("adesM", 32'(adesM), 32'(v.wr & mis));
      chk("badvaddrM", badvaddrM, v.addr);
      if (v.rst) chk("wstrb_in_reset", 32'(bus.data_wstrb), 32'h0);
      if (v.ereq) begin
        chk("data_addr", bus.data_addr, pend_addr);
        chk("data_wr", 32'(bus.data_wr), 32'(pend_wr));
        chk("data_size", 32'(bus.data_size), 32'(pend_sz));
        chk("data_wstrb", 32'(bus.data_wstrb), pend_wr ? 32'(strb_m(pend_sz, pend_addr)) : 32'h0);
        if (pend_wr) chk("data_wdata", bus.data_wdata, wdata_m(pend_sz, pend_rt));
      end
      for (int k = 0; k < v.ln; k++) begin
        case (v.lk[k])
          1: chk("lit_rdataM", rdataM, v.lv[k]);
          2: chk("lit_wdata", bus.data_wdata, v.lv[k]);
          3: chk("lit_wstrb", 32'(bus.data_wstrb), v.lv[k]);
          4: chk("lit_addr", bus.data_addr, v.lv[k]);
          5: chk("lit_badvaddr", badvaddrM, v.lv[k]);
          default: chk("lit_addr_err", 32'({adesM, adelM}), v.lv[k]);
        endcase
      end
      if (v.rst) begin
        pend_v = 1'b0; out_v = 1'b0; exp_rdata = 32'h0;
      end else begin
        if (out_v) begin
          if (v.flush) out_kill = 1'b1;
          if (v.dok) begin
            if (!out_kill && !out_wr) exp_rdata = load_m(out_sz, out_sgn, out_addr, v.rdata);
            out_v = 1'b0;
          end
        end
        if (pend_v) begin
          if (v.flush) pend_kill = 1'b1;
          if (v.aok && v.ereq) begin
            out_v = 1'b1; out_wr = pend_wr; out_sz = pend_sz; out_sgn = pend_sgn;
            out_addr = pend_addr; out_kill = pend_kill; pend_v = 1'b0;
          end
        end
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
